// File: rtl/grid_figure_selector.sv
// grid_figure_selector: cursor/zoom controller for a figure grid with a blinking selection border and registered pixel colour
module grid_figure_selector #(
   parameter int COLS         = 3,
   parameter int ROWS         = 3,
   parameter int RGB_W        = 3,
   parameter int GRID_Y0      = 25,
   parameter int CELL_W       = 214,
   parameter int CELL_H       = 146,
   parameter int LINE_W       = 2,
   parameter int SEL_W        = 4,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [9:0]           HCount,
   input  logic [9:0]           VCount,
   input  logic                 btn_up,
   input  logic                 btn_down,
   input  logic                 btn_left,
   input  logic                 btn_right,
   input  logic                 btn_enter,
   input  logic                 btn_back,
   input  logic                 figure_pixel,
   input  logic                 text_top_pixel,
   input  logic                 text_bottom_pixel,
   input  logic                 text_figure_pixel,
   output logic [ROWS*COLS-1:0] sel_onehot,
   output logic                 full_screen,
   output logic [RGB_W-1:0]     rgb,
   output logic                 frame_tick
);
   localparam int N  = ROWS * COLS;
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [RGB_W-1:0] FIG_C  = RGB_W'(3'b001);
   localparam logic [RGB_W-1:0] SEL_C  = RGB_W'(3'b100);
   localparam logic [RGB_W-1:0] GRID_C = RGB_W'(3'b110);
   localparam logic [RGB_W-1:0] FTXT_C = RGB_W'(3'b011);
   localparam logic [RGB_W-1:0] BG_C   = RGB_W'(3'b000);

   typedef enum logic {BROWSE, ZOOM} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    col, col_n;
   logic [RW-1:0]    row, row_n;
   logic [N-1:0]     onehot_n;
   logic [FW-1:0]    frame_cnt;
   logic             blink, moved;
   logic [31:0]      px, py, x0, y0;
   logic             grid_y, v_line, h_line, in_cell, border;
   logic [RGB_W-1:0] rgb_n;

   // Next cursor/state: enter wins over arrows in BROWSE, arrows ignored in ZOOM, opposite arrows cancel
   always_comb begin
      state_n = state;
      col_n   = col;
      row_n   = row;
      if (state == BROWSE) begin
         if (btn_enter) state_n = ZOOM;
         else begin
            col_n = (btn_right && !btn_left) ? ((col == CW'(COLS - 1)) ? '0 : col + CW'(1)) :
                    (btn_left && !btn_right) ? ((col == '0) ? CW'(COLS - 1) : col - CW'(1)) : col;
            row_n = (btn_down && !btn_up) ? ((row == RW'(ROWS - 1)) ? '0 : row + RW'(1)) :
                    (btn_up && !btn_down) ? ((row == '0) ? RW'(ROWS - 1) : row - RW'(1)) : row;
         end
      end else if (btn_enter || btn_back) state_n = BROWSE;
      moved    = (state_n != state) || (col_n != col) || (row_n != row);
      onehot_n = N'(1) << (int'(row_n) * COLS + int'(col_n));
   end

   // Control registers: FSM, cursor, frame tick and blink timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BROWSE;
         col         <= '0;
         row         <= '0;
         sel_onehot  <= N'(1);
         full_screen <= 1'b0;
         frame_tick  <= 1'b0;
         frame_cnt   <= '0;
         blink       <= 1'b1;
      end else begin
         state       <= state_n;
         col         <= col_n;
         row         <= row_n;
         sel_onehot  <= onehot_n;
         full_screen <= (state_n == ZOOM);
         frame_tick  <= (HCount == 10'd0) && (VCount == 10'd0);
         if (moved) begin
            frame_cnt <= '0;
            blink     <= 1'b1;
         end else if (frame_tick) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
               frame_cnt <= '0;
               blink     <= ~blink;
            end else frame_cnt <= frame_cnt + FW'(1);
         end
      end
   end

   // Pixel classification against grid lines and the cursor cell, then colour priority
   always_comb begin
      px     = 32'(HCount);
      py     = 32'(VCount);
      x0     = 32'(col) * CELL_W;
      y0     = 32'(GRID_Y0) + 32'(row) * CELL_H;
      grid_y = (py >= GRID_Y0) && (py < GRID_Y0 + ROWS * CELL_H + LINE_W);
      v_line = 1'b0;
      h_line = 1'b0;
      for (int c = 1; c < COLS; c++)
         v_line = v_line | (grid_y && (px >= 32'(c * CELL_W - LINE_W)) && (px < 32'(c * CELL_W)));
      for (int r = 0; r <= ROWS; r++)
         h_line = h_line | ((px < COLS * CELL_W) && (py >= 32'(GRID_Y0 + r * CELL_H)) &&
                            (py < 32'(GRID_Y0 + r * CELL_H + LINE_W)));
      in_cell = (px >= x0) && (px < x0 + CELL_W) && (py >= y0) && (py < y0 + CELL_H);
      border  = in_cell && ((px < x0 + SEL_W) || (px >= x0 + CELL_W - SEL_W) ||
                            (py < y0 + SEL_W) || (py >= y0 + CELL_H - SEL_W));
      rgb_n   = figure_pixel ? FIG_C :
                (border && state == BROWSE && blink) ? SEL_C :
                (((v_line || h_line || text_bottom_pixel) && state == BROWSE) || text_top_pixel) ? GRID_C :
                (text_figure_pixel && state == ZOOM) ? FTXT_C : BG_C;
   end

   // Registered colour output, one cycle behind the beam position
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rgb <= BG_C;
      else rgb <= rgb_n;
   end
endmodule

// File: tb/tb_grid_figure_selector.sv
// tb_grid_figure_selector: directed and randomized checks of grid_figure_selector against a behavioural model
module tb_grid_figure_selector;
   localparam int W = 214, H = 146, Y0 = 25, NC = 3, NR = 3, BF = 30;
   localparam logic [2:0] FIG = 3'b001, SEL = 3'b100, GRID = 3'b110, FTXT = 3'b011, BG = 3'b000;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [9:0] HCount = '0, VCount = '0;
   logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_enter = 0, btn_back = 0;
   logic       figure_pixel = 0, text_top_pixel = 0, text_bottom_pixel = 0, text_figure_pixel = 0;
   logic [8:0] sel_onehot;
   logic       full_screen, frame_tick;
   logic [2:0] rgb;

   int   n_chk = 0, n_err = 0;
   int   m_row, m_col, m_cnt;
   logic m_zoom, m_blink, m_ft;

   always #5 clk = ~clk;

   grid_figure_selector dut (
      .clk(clk), .rst_n(rst_n), .HCount(HCount), .VCount(VCount),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .btn_enter(btn_enter), .btn_back(btn_back),
      .figure_pixel(figure_pixel), .text_top_pixel(text_top_pixel),
      .text_bottom_pixel(text_bottom_pixel), .text_figure_pixel(text_figure_pixel),
      .sel_onehot(sel_onehot), .full_screen(full_screen), .rgb(rgb), .frame_tick(frame_tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_row = 0; m_col = 0; m_cnt = 0; m_zoom = 0; m_blink = 1; m_ft = 0;
   endtask

   // colour from the drawing rules, using cell index = position / cell size
   function automatic logic [2:0] exp_rgb(int h, int v, logic fig, logic tt, logic tbp, logic tf);
      logic gy, vl, hl, brd;
      int   dy;
      dy  = v - Y0;
      gy  = (v >= Y0) && (v < Y0 + NR * H + 2);
      vl  = gy && ((h + 2) / W >= 1) && ((h + 2) / W <= NC - 1) && ((h + 2) % W < 2);
      hl  = (h < NC * W) && (v >= Y0) && (dy / H <= NR) && (dy % H < 2);
      brd = (v >= Y0) && (dy / H == m_row) && (h / W == m_col) &&
            ((h % W < 4) || (h % W >= W - 4) || (dy % H < 4) || (dy % H >= H - 4));
      return fig ? FIG : (brd && !m_zoom && m_blink) ? SEL :
             (((vl || hl || tbp) && !m_zoom) || tt) ? GRID : (tf && m_zoom) ? FTXT : BG;
   endfunction

   // b = {up, down, left, right, enter, back}; p = {figure, text_top, text_bottom, text_figure}
   task automatic step(input string tag, input logic [5:0] b, input int h, input int v, input logic [3:0] p);
      logic [2:0] er;
      int   nr, nc;
      logic nz, oft;
      {btn_up, btn_down, btn_left, btn_right, btn_enter, btn_back} = b;
      {figure_pixel, text_top_pixel, text_bottom_pixel, text_figure_pixel} = p;
      HCount = 10'(h);
      VCount = 10'(v);
      er = exp_rgb(h, v, p[3], p[2], p[1], p[0]);
      nr = m_row; nc = m_col; nz = m_zoom;
      if (!m_zoom) begin
         if (b[1]) nz = 1;
         else begin
            nc = (m_col + int'(b[2]) - int'(b[3]) + NC) % NC;
            nr = (m_row + int'(b[4]) - int'(b[5]) + NR) % NR;
         end
      end else if (b[1] || b[0]) nz = 0;
      oft  = m_ft;
      m_ft = (h == 0) && (v == 0);
      if (nz != m_zoom || nr != m_row || nc != m_col) begin
         m_cnt = 0; m_blink = 1;
      end else if (oft) begin
         m_cnt++;
         if (m_cnt == BF) begin m_cnt = 0; m_blink = !m_blink; end
      end
      m_row = nr; m_col = nc; m_zoom = nz;
      @(posedge clk); #1;
      chk({tag, "/rgb"}, 32'(rgb), 32'(er));
      chk({tag, "/sel"}, 32'(sel_onehot), 32'(1) << (m_row * NC + m_col));
      chk({tag, "/zoom"}, 32'(full_screen), 32'(m_zoom));
      chk({tag, "/ftick"}, 32'(frame_tick), 32'(m_ft));
   endtask

   // asynchronous reset mid-cycle, checked before any clock edge
   task automatic do_reset(input string tag);
      #2;
      rst_n = 0;
      {btn_up, btn_down, btn_left, btn_right, btn_enter, btn_back} = '0;
      #1;
      chk({tag, "/rst_zoom"}, 32'(full_screen), 0);
      chk({tag, "/rst_sel"}, 32'(sel_onehot), 1);
      chk({tag, "/rst_rgb"}, 32'(rgb), 32'(BG));
      chk({tag, "/rst_ftick"}, 32'(frame_tick), 0);
      m_reset();
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   function automatic int pick(input int base, input int pitch);
      int x;
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1023));
      x = base + int'($urandom_range(0, 3)) * pitch + int'($urandom_range(0, 10)) - 5;
      return (x < 0) ? 0 : x;
   endfunction

   task automatic rand_phase(input string tag, input int n, input int btn_odds, input int zero_odds);
      logic [5:0] b;
      logic [3:0] p;
      int h, v;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 6; j++) b[j] = ($urandom_range(0, btn_odds - 1) == 0);
         p[3] = ($urandom_range(0, 7) == 0);
         for (int j = 0; j < 3; j++) p[j] = ($urandom_range(0, 3) == 0);
         h = pick(0, W);
         v = pick(Y0, H);
         if ($urandom_range(0, zero_odds - 1) == 0) begin h = 0; v = 0; end
         step(tag, b, h, v, p);
      end
   endtask

   initial begin
      logic [8:0] held;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset/sel", 32'(sel_onehot), 1);
      chk("reset/zoom", 32'(full_screen), 0);
      chk("reset/rgb", 32'(rgb), 32'(BG));
      chk("reset/ftick", 32'(frame_tick), 0);
      rst_n = 1;
      step("right1", 6'b000100, 500, 900, 4'b0); chk("right1_sel", 32'(sel_onehot), 32'h002);
      step("right2", 6'b000100, 500, 900, 4'b0); chk("right2_sel", 32'(sel_onehot), 32'h004);
      step("right3", 6'b000100, 500, 900, 4'b0); chk("right_wrap_sel", 32'(sel_onehot), 32'h001);
      step("up_wrap", 6'b100000, 500, 900, 4'b0); chk("up_wrap_sel", 32'(sel_onehot), 32'h040);
      do_reset("rst1");
      step("lrd", 6'b011100, 500, 900, 4'b0); chk("cancel_lr_sel", 32'(sel_onehot), 32'h008);
      step("enter", 6'b000010, 500, 900, 4'b0); chk("enter_zoom", 32'(full_screen), 1);
      held = sel_onehot;
      step("zarrow1", 6'b111100, 500, 900, 4'b0);
      step("zarrow2", 6'b000100, 500, 900, 4'b0); chk("zoom_arrows_held", 32'(sel_onehot), 32'(held));
      step("back", 6'b000001, 500, 900, 4'b0); chk("back_browse", 32'(full_screen), 0);
      step("bback", 6'b000001, 500, 900, 4'b0); chk("back_in_browse", 32'(full_screen), 0);
      step("vline", 6'b0, 213, 100, 4'b0); chk("vline_browse", 32'(rgb), 32'(GRID));
      step("vfig", 6'b0, 213, 100, 4'b1000); chk("fig_browse", 32'(rgb), 32'(FIG));
      step("zenter", 6'b000010, 213, 100, 4'b0);
      step("vzoom", 6'b0, 213, 100, 4'b0); chk("vline_zoom", 32'(rgb), 32'(BG));
      step("vzfig", 6'b0, 213, 100, 4'b1000); chk("fig_zoom", 32'(rgb), 32'(FIG));
      step("ftxt", 6'b0, 300, 300, 4'b0001); chk("ftxt_zoom", 32'(rgb), 32'(FTXT));
      do_reset("rst2");
      step("selvis", 6'b0, 2, 60, 4'b0); chk("sel_visible", 32'(rgb), 32'(SEL));
      repeat (31) step("ticks", 6'b0, 0, 0, 4'b0);
      step("selhid", 6'b0, 2, 60, 4'b0); chk("sel_hidden", 32'(rgb), 32'(BG));
      step("down", 6'b010000, 2, 60, 4'b0);
      step("selvis2", 6'b0, 2, 181, 4'b0); chk("sel_visible_after_move", 32'(rgb), 32'(SEL));
      step("zent", 6'b000010, 0, 0, 4'b0);
      repeat (31) step("zticks", 6'b0, 0, 0, 4'b0);
      step("zfig", 6'b0, 0, 0, 4'b1000); chk("pre_reset_rgb", 32'(rgb), 32'(FIG));
      do_reset("rst_zoom");
      step("first_btn", 6'b000100, 500, 900, 4'b0); chk("first_btn_sel", 32'(sel_onehot), 32'h002);
      rand_phase("rnd_busy", 1500, 8, 6);
      rand_phase("rnd_quiet", 1500, 300, 2);
      rand_phase("rnd_mix", 1000, 30, 3);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
